// File: rtl/stack_irq_ctrl.sv
// rtl/stack_irq_ctrl.sv - return-address stack sequencer with prioritised interrupt entry/exit
module stack_irq_ctrl #(
    parameter int                N_IRQ    = 4,
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 15,
    parameter logic [ADDR_W-1:0] VEC_BASE = 10'h3F0,
    localparam int               DEPTH_W  = $clog2(DEPTH + 1),
    localparam int               ID_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_IRQ-1:0]   irq,
    input  logic [N_IRQ-1:0]   irq_en,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               cpu_call,
    input  logic               cpu_ret,
    input  logic               reti_flag,
    input  logic               err_clr,
    input  logic [ADDR_W-1:0]  stk_dout,
    output logic               stk_push,
    output logic               stk_pop,
    output logic               stk_intr,
    output logic [ADDR_W-1:0]  stk_din,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               stall,
    output logic [N_IRQ-1:0]   irq_ack,
    output logic [N_IRQ-1:0]   in_service,
    output logic [DEPTH_W-1:0] depth,
    output logic               err_ovf,
    output logic               err_unf
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INT_PUSH = 2'd1,
        INT_VEC  = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   id;

    logic [N_IRQ-1:0]  pend;
    logic [ID_W-1:0]   pend_idx;
    logic [ID_W-1:0]   svc_idx;
    logic              irq_elig;
    logic              full;
    logic              empty;
    logic              take_irq;
    logic              do_ret;
    logic              do_call;
    logic              ovf_evt;
    logic              unf_evt;

    // Pending/eligibility decode: lowest index wins, nesting only above the best in-service line
    always_comb begin
        pend     = irq & irq_en & ~in_service;
        pend_idx = '0;
        svc_idx  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pend_idx = ID_W'(i);
            end
            if (in_service[i]) begin
                svc_idx = ID_W'(i);
            end
        end
        irq_elig = (|pend) && ((in_service == '0) || (pend_idx < svc_idx));
        full     = (depth == DEPTH_W'(DEPTH));
        empty    = (depth == '0);
        take_irq = (state == IDLE) && irq_elig && !full;
        do_ret   = (state == IDLE) && !take_irq && cpu_ret && !empty;
        do_call  = (state == IDLE) && !take_irq && !cpu_ret && cpu_call && !full;
        ovf_evt  = (state == IDLE) && full && (irq_elig || (cpu_call && !cpu_ret));
        unf_evt  = (state == IDLE) && !take_irq && cpu_ret && empty;
    end

    // Strobes and PC load decoded from state; ret/call respond in the same cycle they are seen
    always_comb begin
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_intr  = 1'b0;
        stk_din   = '0;
        pc_load   = 1'b0;
        pc_target = '0;
        stall     = 1'b0;
        irq_ack   = '0;
        if (!reset) begin
            stk_din = pc;
            case (state)
                IDLE: begin
                    if (take_irq) begin
                        stall = 1'b1;
                    end else if (do_ret) begin
                        pc_load   = 1'b1;
                        pc_target = stk_dout;
                        stk_pop   = 1'b1;
                        stk_intr  = reti_flag;
                    end else if (do_call) begin
                        stk_push = 1'b1;
                    end
                end
                INT_PUSH: begin
                    stk_push = 1'b1;
                    stall    = 1'b1;
                end
                INT_VEC: begin
                    pc_load   = 1'b1;
                    pc_target = VEC_BASE + ADDR_W'(id);
                    irq_ack   = N_IRQ'(1) << id;
                    stall     = 1'b1;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, stack depth, in-service set and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            id         <= '0;
            depth      <= '0;
            in_service <= '0;
            err_ovf    <= 1'b0;
            err_unf    <= 1'b0;
        end else begin
            err_ovf <= ovf_evt | (err_ovf & ~err_clr);
            err_unf <= unf_evt | (err_unf & ~err_clr);
            case (state)
                IDLE: begin
                    if (take_irq) begin
                        id    <= pend_idx;
                        state <= INT_PUSH;
                    end else if (do_ret) begin
                        depth <= depth - DEPTH_W'(1);
                        if (reti_flag) begin
                            in_service <= in_service & (in_service - N_IRQ'(1));
                        end
                    end else if (do_call) begin
                        depth <= depth + DEPTH_W'(1);
                    end
                end
                INT_PUSH: begin
                    depth <= depth + DEPTH_W'(1);
                    state <= INT_VEC;
                end
                INT_VEC: begin
                    in_service[id] <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
